// File: rtl/servo_cmd_pkg.sv
// Shared constants, FSM state type and zone-to-position decode for servo_cmd_gen.
package servo_cmd_pkg;

   localparam int POS_CENTER = 544;
   localparam int ZONE_WIDTH = 33;
   localparam int POS_MIN    = 228;
   localparam int POS_MAX    = 830;
   localparam int MAX_DIGIT  = 9;

   typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

   // Signed 11-bit so the left-side subtraction and both clamps stay exact.
   function automatic logic [9:0] zone_to_pos(input logic [3:0] digit, input logic side);
      logic signed [10:0] offset;
      logic signed [10:0] pos;
      offset = $signed(11'(digit) * 11'(ZONE_WIDTH));
      pos    = side ? $signed(11'(POS_CENTER)) + offset : $signed(11'(POS_CENTER)) - offset;
      if (pos < $signed(11'(POS_MIN)))
         pos = 11'(POS_MIN);
      else if (pos > $signed(11'(POS_MAX)))
         pos = 11'(POS_MAX);
      return pos[9:0];
   endfunction

endpackage

// File: rtl/servo_pwm.sv
// Free-running servo PWM frame: latches the position at count 0 and holds it for the whole frame.
module servo_pwm
   import servo_cmd_pkg::*;
#(
   parameter int FRAME_CYCLES = 1000000,
   parameter int PULSE_MULT   = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] pos,
   output logic       pwm_out,
   output logic       frame_start,
   output logic       frame_end
);

   logic [19:0] frame_cnt;
   logic [9:0]  lat_pos;
   logic [9:0]  eff_pos;
   logic [19:0] high_len;

   assign frame_start = (frame_cnt == 20'd0);
   assign frame_end   = (frame_cnt == 20'(FRAME_CYCLES - 1));
   // On the latch cycle the compare must already see the new frame's position.
   assign eff_pos     = frame_start ? pos : lat_pos;
   assign high_len    = 20'(eff_pos) * 20'(PULSE_MULT);

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         lat_pos   <= 10'(POS_CENTER);
         pwm_out   <= 1'b0;
      end else begin
         frame_cnt <= frame_end ? 20'd0 : frame_cnt + 20'd1;
         if (frame_start)
            lat_pos <= pos;
         pwm_out <= (frame_cnt < high_len);
      end
   end

endmodule

// File: rtl/servo_cmd_gen.sv
// Zone command to servo position: decode, handshake, IDLE/MOVE/SETTLE FSM and rate-limited ramp.
// Build option SERVO_CMD_RAMP_EN: defined = ramp STEP units every RAMP_DIV clocks, undefined = jump in one cycle.
module servo_cmd_gen
   import servo_cmd_pkg::*;
#(
   parameter int FRAME_CYCLES = 1000000,
   parameter int PULSE_MULT   = 120,
   parameter int RAMP_DIV     = 250000,
   parameter int STEP         = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_digit,
   input  logic       cmd_side,
   output logic [9:0] target_pos,
   output logic [9:0] cur_pos,
   output logic       pwm_out,
   output logic       busy,
   output logic       move_done,
   output logic       cmd_err
);

   state_t state, state_nxt;
   logic   xfer, legal, accept;
   logic   frame_start, frame_end;
   logic   armed, done_evt, move_ok;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign xfer      = cmd_valid & cmd_ready;
   assign legal     = (cmd_digit <= 4'(MAX_DIGIT));
   assign accept    = xfer & legal;
   assign done_evt  = (state == SETTLE) && frame_end && armed;

`ifdef SERVO_CMD_RAMP_EN
   localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [DW-1:0] ramp_cnt;
   logic          ramp_tick;
   logic [9:0]    gap, stride, ramp_pos;

   assign ramp_tick = (ramp_cnt == DW'(RAMP_DIV - 1));
   assign move_ok   = (cur_pos == target_pos);

   always_comb begin
      gap      = (target_pos > cur_pos) ? target_pos - cur_pos : cur_pos - target_pos;
      stride   = (gap > 10'(STEP)) ? 10'(STEP) : gap;
      ramp_pos = (target_pos > cur_pos) ? cur_pos + stride : cur_pos - stride;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ramp_cnt <= '0;
         cur_pos  <= 10'(POS_CENTER);
      end else if (accept) begin
         ramp_cnt <= '0;
      end else if (state == MOVE) begin
         ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
         if (ramp_tick)
            cur_pos <= ramp_pos;
      end
   end
`else
   localparam int unused_ramp_cfg = RAMP_DIV + STEP;

   assign move_ok = 1'b1;

   always_ff @(posedge clk) begin
      if (reset)
         cur_pos <= 10'(POS_CENTER);
      else if (state == MOVE)
         cur_pos <= target_pos;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = MOVE;
         MOVE:    if (move_ok)  state_nxt = SETTLE;
         SETTLE:  if (done_evt) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // armed: the frame now playing was latched at the current target after the last acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         target_pos <= 10'(POS_CENTER);
         armed      <= 1'b0;
         move_done  <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         move_done <= done_evt;
         cmd_err   <= xfer & ~legal;
         if (accept) begin
            target_pos <= zone_to_pos(cmd_digit, cmd_side);
            armed      <= 1'b0;
         end else if (frame_start) begin
            armed <= (cur_pos == target_pos);
         end
      end
   end

   servo_pwm #(
      .FRAME_CYCLES (FRAME_CYCLES),
      .PULSE_MULT   (PULSE_MULT)
   ) u_pwm (
      .clk         (clk),
      .reset       (reset),
      .pos         (cur_pos),
      .pwm_out     (pwm_out),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

endmodule

// File: tb/tb_servo_cmd_gen.sv
// Directed bench for servo_cmd_gen (FRAME 2000, MULT 2, RAMP_DIV 10, STEP 4); adapts to SERVO_CMD_RAMP_EN.
module tb_servo_cmd_gen;

   localparam int FRAME = 2000;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_digit;
   logic       cmd_side;
   logic [9:0] target_pos;
   logic [9:0] cur_pos;
   logic       pwm_out;
   logic       busy;
   logic       move_done;
   logic       cmd_err;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   bit pwm_hist [0:FRAME-1];
   int hidx = 0;

   servo_cmd_gen #(
      .FRAME_CYCLES (FRAME),
      .PULSE_MULT   (2),
      .RAMP_DIV     (10),
      .STEP         (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_digit  (cmd_digit),
      .cmd_side   (cmd_side),
      .target_pos (target_pos),
      .cur_pos    (cur_pos),
      .pwm_out    (pwm_out),
      .busy       (busy),
      .move_done  (move_done),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   // Pulse counters and a one-frame pwm history, sampled at posedge (pre-edge values).
   always @(posedge clk) begin
      done_cnt        <= done_cnt + int'(move_done);
      err_cnt         <= err_cnt + int'(cmd_err);
      pwm_hist[hidx]  <= pwm_out;
      hidx            <= (hidx + 1) % FRAME;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Waits for move_done; pulse = high cycles of the frame that just ended.
   task automatic wait_done(output bit got, output int pulse);
      got   = 1'b0;
      pulse = 0;
      for (int i = 0; i < 9000; i++) begin
         @(negedge clk);
         if (move_done) begin
            got = 1'b1;
            for (int k = 0; k < FRAME; k++) pulse += int'(pwm_hist[k]);
            break;
         end
      end
   endtask

   initial begin
      bit got;
      int pulse;
      int hi;
      int d0;
      int exp_cur;

      // Reset with a command presented: must be dropped.
      reset = 1'b1; cmd_valid = 1'b1; cmd_digit = 4'd3; cmd_side = 1'b1;
      repeat (3) step();
      reset = 1'b0; cmd_valid = 1'b0;
      chk("rst_cur", cur_pos, 544);
      chk("rst_target", target_pos, 544);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pwm", pwm_out, 0);
      chk("rst_done", move_done, 0);
      chk("rst_err", cmd_err, 0);

      // First frame: 1088 high then 912 low.
      hi = 0;
      for (int i = 1; i <= FRAME; i++) begin
         step();
         hi += int'(pwm_out);
         if (i == 1)    chk("frame0_first_hi", pwm_out, 1);
         if (i == 1088) chk("frame0_last_hi", pwm_out, 1);
         if (i == 1089) chk("frame0_first_lo", pwm_out, 0);
      end
      chk("frame0_hi", hi, 1088);
      chk("frame0_lo", FRAME - hi, 912);

      // Illegal digit.
      cmd_valid = 1'b1; cmd_digit = 4'd12; cmd_side = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("bad_err", cmd_err, 1);
      chk("bad_ready", cmd_ready, 1);
      chk("bad_busy", busy, 0);
      chk("bad_target", target_pos, 544);
      chk("bad_cur", cur_pos, 544);
      step();
      chk("bad_err_clr", cmd_err, 0);

      // Digit 0, left: target equals current position.
      cmd_valid = 1'b1; cmd_digit = 4'd0; cmd_side = 1'b0;
      step();
      cmd_valid = 1'b0;
      chk("z_target", target_pos, 544);
      chk("z_busy", busy, 1);
      chk("z_ready", cmd_ready, 0);
      step();
      chk("z_cur", cur_pos, 544);
      wait_done(got, pulse);
      chk("z_done_seen", got, 1);
      chk("z_pulse", pulse, 1088);
      chk("z_ready_at_done", cmd_ready, 1);
      chk("z_busy_at_done", busy, 0);

      // Right 3, then right 9 held on the bus while the move runs.
      cmd_valid = 1'b1; cmd_digit = 4'd3; cmd_side = 1'b1;
      step();
      chk("r3_target", target_pos, 643);
      chk("r3_busy", busy, 1);
      chk("r3_ready", cmd_ready, 0);
      chk("r3_done_cnt", done_cnt, 1);
      cmd_digit = 4'd9;
`ifdef SERVO_CMD_RAMP_EN
      for (int j = 1; j <= 250; j++) begin
         if (j > 1) step();
         exp_cur = 544 + 4 * (j / 10);
         if (exp_cur > 643) exp_cur = 643;
         chk("r3_ramp", cur_pos, exp_cur);
      end
`else
      chk("r3_cur_hold", cur_pos, 544);
      step();
      chk("r3_cur_jump", cur_pos, 643);
`endif
      wait_done(got, pulse);
      chk("r3_done_seen", got, 1);
      chk("r3_pulse", pulse, 1286);
      chk("r3_held_target", target_pos, 643);
      chk("r3_ready_at_done", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
      chk("r9_target", target_pos, 830);
      chk("r9_busy", busy, 1);
      chk("r3_done_once", done_cnt, 2);

      wait_done(got, pulse);
      chk("r9_done_seen", got, 1);
      chk("r9_pulse", pulse, 1660);
      chk("r9_cur", cur_pos, 830);

      // Left 9.
      cmd_valid = 1'b1; cmd_digit = 4'd9; cmd_side = 1'b0;
      step();
      cmd_valid = 1'b0;
      chk("l9_target", target_pos, 247);
      wait_done(got, pulse);
      chk("l9_done_seen", got, 1);
      chk("l9_pulse", pulse, 494);
      chk("l9_cur", cur_pos, 247);

      // Left 4.
      cmd_valid = 1'b1; cmd_digit = 4'd4; cmd_side = 1'b0;
      step();
      cmd_valid = 1'b0;
      chk("l4_target", target_pos, 412);
      chk("l4_cur_n1", cur_pos, 247);
      step();
`ifdef SERVO_CMD_RAMP_EN
      chk("l4_cur_n2", cur_pos, 247);
`else
      chk("l4_cur_n2", cur_pos, 412);
`endif
      wait_done(got, pulse);
      chk("l4_done_seen", got, 1);
      chk("l4_pulse", pulse, 824);

      // Reset in the middle of a right 3 move.
      cmd_valid = 1'b1; cmd_digit = 4'd3; cmd_side = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("mr_target", target_pos, 643);
      repeat (24) step();
`ifdef SERVO_CMD_RAMP_EN
      chk("mr_cur_mid", cur_pos, 420);
`else
      chk("mr_cur_mid", cur_pos, 643);
`endif
      d0 = done_cnt;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_cur", cur_pos, 544);
      chk("mr_target_rst", target_pos, 544);
      chk("mr_pwm", pwm_out, 0);
      chk("mr_busy", busy, 0);
      chk("mr_ready", cmd_ready, 1);
      chk("mr_done", move_done, 0);
      repeat (3000) step();
      chk("mr_no_done", done_cnt, d0);
      chk("err_total", err_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
